// File: rtl/prime_search_engine_if.sv
// Start/done handshake bundle for the prime search coprocessor.
// The master drives the request; the slave returns the result.
interface prime_search_engine_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             start;
  logic [WIDTH-1:0] seed;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] prime;
  logic             fail;
  logic [CNT_W-1:0] candidates;

  modport master (
    output start, seed,
    input  busy, done, prime, fail, candidates
  );

  modport slave (
    input  start, seed,
    output busy, done, prime, fail, candidates
  );
endinterface

// File: rtl/prime_search_engine.sv
// Smallest probable prime >= seed via Miller-Rabin
// on a bit-serial shift-add modular multiplier.
module prime_search_engine #(
  parameter int WIDTH     = 32,
  parameter int NUM_BASES = 4,
  parameter int CNT_W     = 16
) (
  input  logic clk,
  input  logic rst_n,
  prime_search_engine_if.slave bus
);
  localparam int BW = $clog2(WIDTH);
  localparam int SW = BW + 1;
  localparam logic [3:0] LP_NB = 4'(NUM_BASES);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DECOMP, S_EXP,
    S_SQR, S_NEXT, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    P_INIT, P_RED, P_SQ, P_MUL, P_ADV
  } phase_t;

  function automatic logic [WIDTH-1:0] base_of(
    input logic [3:0] k
  );
    logic [5:0] b;
    case (k)
      4'd0:    b = 6'd2;
      4'd1:    b = 6'd3;
      4'd2:    b = 6'd5;
      4'd3:    b = 6'd7;
      4'd4:    b = 6'd11;
      4'd5:    b = 6'd13;
      4'd6:    b = 6'd17;
      4'd7:    b = 6'd19;
      4'd8:    b = 6'd23;
      4'd9:    b = 6'd29;
      4'd10:   b = 6'd31;
      4'd11:   b = 6'd37;
      default: b = 6'd2;
    endcase
    return {{(WIDTH-6){1'b0}}, b};
  endfunction

  state_t           r_state;
  phase_t           r_ph;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_d;
  logic [SW-1:0]    r_s;
  logic [SW-1:0]    r_j;
  logic [3:0]       r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_y;
  logic [BW-1:0]    r_bit;
  logic             r_small;
  logic             r_mm_go;
  logic [BW-1:0]    r_mm_cnt;
  logic [WIDTH-1:0] r_mm_r;
  logic [WIDTH-1:0] r_mm_x;
  logic [WIDTH-1:0] r_mm_b;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_prime;
  logic             r_fail;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_nx;
  logic [WIDTH:0]   w_dbl;
  logic [WIDTH:0]   w_d1;
  logic [WIDTH:0]   w_ad;
  logic [WIDTH:0]   w_a1;
  logic [WIDTH-1:0] w_mm_nxt;
  logic             w_mm_last;
  logic [WIDTH-1:0] w_nm1;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_unused;

  // One mulmod step: r = 2r mod n, then + x mod n on a set bit.
  always_comb begin
    w_nx  = {1'b0, r_n};
    w_dbl = {r_mm_r, 1'b0};
    w_d1  = (w_dbl >= w_nx) ? w_dbl - w_nx : w_dbl;
    w_ad  = w_d1 + {1'b0, r_mm_x};
    w_a1  = (w_ad >= w_nx) ? w_ad - w_nx : w_ad;
    w_mm_nxt = r_mm_b[WIDTH-1] ? w_a1[WIDTH-1:0]
                               : w_d1[WIDTH-1:0];
    w_mm_last = (r_mm_cnt == BW'(WIDTH-1));
    w_nm1 = r_n - WIDTH'(1);
    w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  end

  assign w_unused = ^{w_a1[WIDTH]};

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.prime      = r_prime;
  assign bus.fail       = r_fail;
  assign bus.candidates = r_cnt;

  // Search sequencer with embedded serial mulmod datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ph     <= P_INIT;
      r_n      <= '0;
      r_d      <= '0;
      r_s      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_a      <= '0;
      r_y      <= '0;
      r_bit    <= '0;
      r_small  <= 1'b0;
      r_mm_go  <= 1'b0;
      r_mm_cnt <= '0;
      r_mm_r   <= '0;
      r_mm_x   <= '0;
      r_mm_b   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_prime  <= '0;
      r_fail   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (r_mm_go) begin
        r_mm_r   <= w_mm_nxt;
        r_mm_b   <= {r_mm_b[WIDTH-2:0], 1'b0};
        r_mm_cnt <= r_mm_cnt + BW'(1);
        if (w_mm_last) r_mm_go <= 1'b0;
      end
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_n     <= bus.seed | WIDTH'(1);
            r_small <= (bus.seed <= WIDTH'(2));
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (r_small) begin
            r_prime <= WIDTH'(2);
            r_fail  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_d     <= w_nm1;
            r_s     <= '0;
            r_state <= S_DECOMP;
          end
        end
        S_DECOMP: begin
          if (!r_d[0]) begin
            r_d <= {1'b0, r_d[WIDTH-1:1]};
            r_s <= r_s + SW'(1);
          end else begin
            r_k     <= '0;
            r_ph    <= P_INIT;
            r_state <= S_EXP;
          end
        end
        S_EXP: begin
          if (r_mm_go) begin
            if (w_mm_last) begin
              r_y  <= w_mm_nxt;
              r_ph <= (r_ph == P_SQ) ? P_MUL : P_ADV;
            end
          end else begin
            unique case (r_ph)
              P_INIT: begin
                if (r_k == LP_NB) begin
                  r_cnt   <= w_cnt_inc;
                  r_prime <= r_n;
                  r_fail  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
                end else begin
                  r_a  <= base_of(r_k);
                  r_ph <= P_RED;
                end
              end
              P_RED: begin
                if (r_a >= r_n) begin
                  r_a <= r_a - r_n;
                end else if (r_a == '0) begin
                  r_k  <= r_k + 4'd1;
                  r_ph <= P_INIT;
                end else begin
                  r_y   <= WIDTH'(1);
                  r_bit <= BW'(WIDTH-1);
                  r_ph  <= P_SQ;
                end
              end
              P_SQ: begin
                if (r_y != WIDTH'(1)) begin
                  r_mm_go  <= 1'b1;
                  r_mm_cnt <= '0;
                  r_mm_r   <= '0;
                  r_mm_x   <= r_y;
                  r_mm_b   <= r_y;
                end else begin
                  r_ph <= P_MUL;
                end
              end
              P_MUL: begin
                if (!r_d[r_bit]) begin
                  r_ph <= P_ADV;
                end else if (r_y == WIDTH'(1)) begin
                  r_y  <= r_a;
                  r_ph <= P_ADV;
                end else begin
                  r_mm_go  <= 1'b1;
                  r_mm_cnt <= '0;
                  r_mm_r   <= '0;
                  r_mm_x   <= r_a;
                  r_mm_b   <= r_y;
                end
              end
              P_ADV: begin
                if (r_bit == '0) begin
                  r_j     <= '0;
                  r_state <= S_SQR;
                end else begin
                  r_bit <= r_bit - BW'(1);
                  r_ph  <= P_SQ;
                end
              end
              default: r_ph <= P_INIT;
            endcase
          end
        end
        S_SQR: begin
          if (r_mm_go) begin
            if (w_mm_last) begin
              r_y <= w_mm_nxt;
              r_j <= r_j + SW'(1);
            end
          end else if ((r_j == '0 && r_y == WIDTH'(1)) ||
                       r_y == w_nm1) begin
            r_k     <= r_k + 4'd1;
            r_ph    <= P_INIT;
            r_state <= S_EXP;
          end else if (r_y == WIDTH'(1) ||
                       r_j == r_s - SW'(1)) begin
            r_state <= S_NEXT;
          end else begin
            r_mm_go  <= 1'b1;
            r_mm_cnt <= '0;
            r_mm_r   <= '0;
            r_mm_x   <= r_y;
            r_mm_b   <= r_y;
          end
        end
        S_NEXT: begin
          r_cnt <= w_cnt_inc;
          if (&r_n) begin
            r_prime <= '0;
            r_fail  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_n     <= r_n + WIDTH'(2);
            r_d     <= r_n + WIDTH'(1);
            r_s     <= '0;
            r_state <= S_DECOMP;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prime_search_engine.sv
// Bench for prime_search_engine against a
// trial-division next-prime reference.
module tb_prime_search_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  prime_search_engine_if #(.WIDTH(32), .CNT_W(16)) bus();

  prime_search_engine #(
    .WIDTH(32), .NUM_BASES(4), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic bit is_prime(longint unsigned v);
    if (v < 2) return 1'b0;
    if (v % 2 == 0) return v == 2;
    for (longint unsigned q = 3; q * q <= v; q += 2)
      if (v % q == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic ref_next(input longint unsigned sd,
                          output longint unsigned p,
                          output bit f, output int c);
    longint unsigned n;
    c = 0; f = 0; p = 2;
    if (sd <= 2) return;
    n = sd | 1;
    forever begin
      c++;
      if (is_prime(n)) begin p = n; return; end
      if (n == 64'hFFFF_FFFF) begin p = 0; f = 1; return; end
      n += 2;
    end
  endtask

  task automatic run_search(input logic [31:0] sd,
                            input bit hammer,
                            output logic [31:0] p,
                            output logic f,
                            output logic [15:0] c,
                            output int cyc,
                            output bit tim_ok,
                            output bit to);
    @(negedge clk);
    bus.seed = sd;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = hammer;
    tim_ok = 1; to = 1; cyc = 0;
    p = '0; f = 1'b0; c = '0;
    for (int i = 0; i < 40000; i++) begin
      if (bus.done === 1'b1) begin
        if (bus.busy !== 1'b0) tim_ok = 0;
        p = bus.prime; f = bus.fail;
        c = bus.candidates; to = 0;
        break;
      end
      if (bus.busy !== 1'b1) tim_ok = 0;
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    if (bus.done !== 1'b0) tim_ok = 0;
    bus.start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) tim_ok = 0;
      if (!to && bus.prime !== p) tim_ok = 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.seed = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.fail} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000",
               {bus.busy, bus.done, bus.fail});
    end
    total++;
    if (bus.prime !== 32'd0 || bus.candidates !== 16'd0) begin
      bad++;
      $display("FAIL reset_data prime=%0d cand=%0d want=0",
               bus.prime, bus.candidates);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_small();
    logic [31:0] sds [3] = '{32'd0, 32'd2, 32'd1};
    logic [31:0] p; logic f; logic [15:0] c;
    int cyc; bit tok, to;
    foreach (sds[i]) begin
      run_search(sds[i], 1'b0, p, f, c, cyc, tok, to);
      total++;
      if (to || p !== 32'd2 || f !== 1'b0 || c !== 16'd0) begin
        bad++;
        $display("FAIL small seed=%0d got p=%0d f=%0d c=%0d to=%0d want p=2 f=0 c=0",
                 sds[i], p, f, c, to);
      end
      total++;
      if (cyc !== 1 || tok !== 1'b1) begin
        bad++;
        $display("FAIL small_timing seed=%0d got cyc=%0d tok=%0d want cyc=1 tok=1",
                 sds[i], cyc, tok);
      end
    end
  endtask

  task automatic test_known();
    logic [31:0] sds [4] = '{32'd14, 32'd24, 32'd2047, 32'd4294967291};
    logic [31:0] eps [4] = '{32'd17, 32'd29, 32'd2053, 32'd4294967291};
    logic [15:0] ecs [4] = '{16'd2, 16'd3, 16'd4, 16'd1};
    logic [31:0] p; logic f; logic [15:0] c;
    int cyc; bit tok, to;
    foreach (sds[i]) begin
      run_search(sds[i], 1'b0, p, f, c, cyc, tok, to);
      total++;
      if (to || p !== eps[i] || f !== 1'b0) begin
        bad++;
        $display("FAIL known seed=%0d got p=%0d f=%0d to=%0d want p=%0d f=0",
                 sds[i], p, f, to, eps[i]);
      end
      total++;
      if (c !== ecs[i] || tok !== 1'b1) begin
        bad++;
        $display("FAIL known_cnt seed=%0d got c=%0d tok=%0d want c=%0d tok=1",
                 sds[i], c, tok, ecs[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] sds [2] = '{32'd4294967292, 32'hFFFF_FFFF};
    logic [15:0] ecs [2] = '{16'd2, 16'd1};
    logic [31:0] p; logic f; logic [15:0] c;
    int cyc; bit tok, to;
    foreach (sds[i]) begin
      run_search(sds[i], 1'b0, p, f, c, cyc, tok, to);
      total++;
      if (to || p !== 32'd0 || f !== 1'b1 || c !== ecs[i] || tok !== 1'b1) begin
        bad++;
        $display("FAIL wrap seed=%0d got p=%0d f=%0d c=%0d tok=%0d to=%0d want p=0 f=1 c=%0d",
                 sds[i], p, f, c, tok, to, ecs[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] p; logic f; logic [15:0] c;
    int cyc; bit tok, to;
    run_search(32'd24, 1'b1, p, f, c, cyc, tok, to);
    total++;
    if (to || p !== 32'd29 || c !== 16'd3 || tok !== 1'b1) begin
      bad++;
      $display("FAIL back_to_back got p=%0d c=%0d tok=%0d to=%0d want p=29 c=3 tok=1",
               p, c, tok, to);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] p; logic f; logic [15:0] c;
    int cyc; bit tok, to;
    bit seen_done = 0;
    @(negedge clk);
    bus.seed = 32'd4294967291;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done = 1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.fail} !== 3'b000 ||
        bus.prime !== 32'd0 || bus.candidates !== 16'd0) begin
      bad++;
      $display("FAIL mid_reset got b=%0d d=%0d f=%0d p=%0d c=%0d want all 0",
               bus.busy, bus.done, bus.fail, bus.prime, bus.candidates);
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done = 1;
    end
    total++;
    if (seen_done) begin
      bad++;
      $display("FAIL mid_reset_done got activity=1 want 0");
    end
    run_search(32'd14, 1'b0, p, f, c, cyc, tok, to);
    total++;
    if (to || p !== 32'd17 || c !== 16'd2 || tok !== 1'b1) begin
      bad++;
      $display("FAIL after_reset got p=%0d c=%0d tok=%0d want p=17 c=2",
               p, c, tok);
    end
  endtask

  task automatic test_random();
    logic [31:0] sd, p; logic f; logic [15:0] c;
    longint unsigned ep; bit ef; int ec;
    int cyc; bit tok, to;
    for (int i = 0; i < 7; i++) begin
      if (i < 3) sd = $urandom_range(0, (1 << 20) - 1);
      else sd = $urandom_range(0, (1 << 12) - 1);
      ref_next(longint'(sd), ep, ef, ec);
      run_search(sd, 1'b0, p, f, c, cyc, tok, to);
      total++;
      if (to || p !== ep[31:0] || f !== ef ||
          c !== ec[15:0] || tok !== 1'b1) begin
        bad++;
        $display("FAIL random seed=%0d got p=%0d f=%0d c=%0d tok=%0d to=%0d want p=%0d f=%0d c=%0d",
                 sd, p, f, c, tok, to, ep, ef, ec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_known();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
